// File: rtl/player_motion_pkg.sv
// Shared types and constants for the player motion controller.
package player_motion_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WALK = 3'd1,
    RISE = 3'd2,
    FALL = 3'd3,
    KICK = 3'd4
  } state_e;

  localparam int unsigned SW_RIGHT = 0;
  localparam int unsigned SW_KICK  = 1;
  localparam int unsigned SW_JUMP  = 2;
  localparam int unsigned SW_LEFT  = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter that only moves on frame ticks; saturates at zero.
module frame_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/player_motion_ctrl.sv
// Frame-rate movement/kick FSM producing registered dx, dy and kick flag.
// Optional feature: define AIR_KICK_EN to accept kicks while airborne.
module player_motion_ctrl
  import player_motion_pkg::*;
#(
  parameter int W               = 11,
  parameter int WALK_SPEED      = 1,
  parameter int JUMP_SPEED      = 5,
  parameter int GRAVITY         = 5,
  parameter int JUMP_FRAMES     = 8,
  parameter int KICK_FRAMES     = 6,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic [3:0]          sw,
  input  logic                on_ground,
  output logic signed [W-1:0] dx,
  output logic signed [W-1:0] dy,
  output logic                kickon,
  output logic [2:0]          state_o
);

  localparam int unsigned CW = $clog2(max3(JUMP_FRAMES, KICK_FRAMES, COOLDOWN_FRAMES) + 1);
  localparam logic [CW-1:0] JUMP_LOAD = CW'(JUMP_FRAMES - 1);
  localparam logic [CW-1:0] KICK_LOAD = CW'(KICK_FRAMES - 1);
  // Loaded with N-1 so a new kick is accepted on the N-th tick after exit.
  localparam logic [CW-1:0] CD_LOAD   = CW'(COOLDOWN_FRAMES - 1);

  localparam logic signed [W-1:0] DX_RIGHT = W'(WALK_SPEED);
  localparam logic signed [W-1:0] DX_LEFT  = W'(-WALK_SPEED);
  localparam logic signed [W-1:0] DY_RISE  = W'(-JUMP_SPEED);
  localparam logic signed [W-1:0] DY_FALL  = W'(GRAVITY);

  state_e              state_q, state_d;
  logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, hdx;
  logic                kick_q, kick_d, armed_q, armed_d;
  logic                jump_load, kick_load, cd_load;
  logic                jump_zero, kick_zero, cd_zero;
  logic                kick_req, jump_req;
  state_e              ground_st;
`ifdef AIR_KICK_EN
  logic                air_q, air_d;
`endif

  always_comb begin
    hdx = '0;
    if (sw[SW_RIGHT] && !sw[SW_LEFT]) begin
      hdx = DX_RIGHT;
    end else if (sw[SW_LEFT] && !sw[SW_RIGHT]) begin
      hdx = DX_LEFT;
    end
  end

  assign kick_req  = sw[SW_KICK] && cd_zero;
  assign jump_req  = sw[SW_JUMP] && armed_q;
  assign ground_st = (hdx != '0) ? WALK : IDLE;

  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    kick_d    = kick_q;
    armed_d   = armed_q;
    jump_load = 1'b0;
    kick_load = 1'b0;
    cd_load   = 1'b0;
`ifdef AIR_KICK_EN
    air_d     = air_q;
`endif
    if (frame_tick) begin
      dx_d   = hdx;
      dy_d   = '0;
      kick_d = 1'b0;
      if (!sw[SW_JUMP]) begin
        armed_d = 1'b1;
      end
      case (state_q)
        IDLE, WALK: begin
          if (kick_req) begin
            state_d   = KICK;
            kick_load = 1'b1;
            kick_d    = 1'b1;
            dx_d      = '0;
          end else if (jump_req) begin
            state_d   = RISE;
            jump_load = 1'b1;
            armed_d   = 1'b0;
            dy_d      = DY_RISE;
          end else if (!on_ground) begin
            state_d = FALL;
            dy_d    = DY_FALL;
          end else begin
            state_d = ground_st;
          end
        end
        RISE: begin
          if (jump_zero) begin
            state_d = FALL;
            dy_d    = DY_FALL;
          end else begin
            dy_d = DY_RISE;
          end
        end
        FALL: begin
          if (on_ground) begin
            state_d = ground_st;
          end else begin
            dy_d = DY_FALL;
          end
        end
        KICK: begin
          dx_d = '0;
          if (kick_zero) begin
            state_d = IDLE;
            cd_load = 1'b1;
          end else begin
            kick_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          dx_d    = '0;
        end
      endcase
`ifdef AIR_KICK_EN
      // Airborne origin is latched on every non-KICK tick; only read inside KICK.
      if (state_q != KICK) begin
        air_d = (state_q == RISE) || (state_q == FALL);
      end
      if (((state_q == RISE) || (state_q == FALL)) && kick_req) begin
        state_d   = KICK;
        kick_load = 1'b1;
        kick_d    = 1'b1;
        dx_d      = '0;
        dy_d      = DY_FALL;
      end else if ((state_q == KICK) && air_q) begin
        if (!kick_zero) begin
          dy_d = DY_FALL;
        end else if (!on_ground) begin
          state_d = FALL;
          dy_d    = DY_FALL;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      kick_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      kick_q  <= kick_d;
      armed_q <= armed_d;
    end
  end

`ifdef AIR_KICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      air_q <= 1'b0;
    end else begin
      air_q <= air_d;
    end
  end
`endif

  frame_down_counter #(.WIDTH(CW)) u_jump_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (frame_tick),
    .load_i     (jump_load),
    .load_val_i (JUMP_LOAD),
    .dec_i      (state_q == RISE),
    .zero_o     (jump_zero)
  );

  frame_down_counter #(.WIDTH(CW)) u_kick_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (frame_tick),
    .load_i     (kick_load),
    .load_val_i (KICK_LOAD),
    .dec_i      (state_q == KICK),
    .zero_o     (kick_zero)
  );

  frame_down_counter #(.WIDTH(CW)) u_cooldown (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (frame_tick),
    .load_i     (cd_load),
    .load_val_i (CD_LOAD),
    .dec_i      (1'b1),
    .zero_o     (cd_zero)
  );

  assign dx      = dx_q;
  assign dy      = dy_q;
  assign kickon  = kick_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl (default build, air kick disabled).
module tb_player_motion_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_WALK = 1;
  localparam int S_RISE = 2;
  localparam int S_FALL = 3;
  localparam int S_KICK = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_tick;
  logic [3:0]         sw;
  logic               on_ground;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               kickon;
  logic [2:0]         state_o;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .sw         (sw),
    .on_ground  (on_ground),
    .dx         (dx),
    .dy         (dy),
    .kickon     (kickon),
    .state_o    (state_o)
  );

  typedef struct {
    int   dx;
    int   dy;
    logic kick;
    int   st;
  } exp_t;

  typedef struct {
    logic [3:0] sw;
    logic       og;
    exp_t       e;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[23];

  function automatic exp_t mk(int edx, int edy, logic ek, int est);
    exp_t r;
    r.dx   = edx;
    r.dy   = edy;
    r.kick = ek;
    r.st   = est;
    return r;
  endfunction

  task automatic check_int(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_out(string tag, exp_t e);
    check_int({tag, ".dx"}, int'(dx), e.dx);
    check_int({tag, ".dy"}, int'(dy), e.dy);
    check_int({tag, ".kickon"}, int'(kickon), int'(e.kick));
    check_int({tag, ".state"}, int'(state_o), e.st);
  endtask

  task automatic do_tick(logic [3:0] s, logic og, exp_t e, string tag);
    exp_t got;
    @(negedge clk);
    sw         = s;
    on_ground  = og;
    frame_tick = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check_out(tag, got);
    end
    @(posedge clk);
  endtask

  task automatic apply_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out({tag, "_async"}, mk(0, 0, 1'b0, S_IDLE));
    @(posedge clk);
    #1;
    check_out({tag, "_held"}, mk(0, 0, 1'b0, S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    frame_tick = 1'b0;
    sw         = 4'b0000;
    on_ground  = 1'b1;

    tbl[0]  = '{4'b0001, 1'b1, mk( 1,  0, 1'b0, S_WALK)};
    tbl[1]  = '{4'b0001, 1'b1, mk( 1,  0, 1'b0, S_WALK)};
    tbl[2]  = '{4'b0001, 1'b1, mk( 1,  0, 1'b0, S_WALK)};
    tbl[3]  = '{4'b1001, 1'b1, mk( 0,  0, 1'b0, S_IDLE)};
    tbl[4]  = '{4'b1000, 1'b1, mk(-1,  0, 1'b0, S_WALK)};
    tbl[5]  = '{4'b0000, 1'b1, mk( 0,  0, 1'b0, S_IDLE)};
    tbl[6]  = '{4'b0101, 1'b1, mk( 1, -5, 1'b0, S_RISE)};
    for (int i = 7; i <= 13; i++) begin
      tbl[i] = '{4'b0100, 1'b0, mk(0, -5, 1'b0, S_RISE)};
    end
    tbl[14] = '{4'b0100, 1'b0, mk( 0,  5, 1'b0, S_FALL)};
    tbl[15] = '{4'b0110, 1'b0, mk( 0,  5, 1'b0, S_FALL)};
    tbl[16] = '{4'b1100, 1'b0, mk(-1,  5, 1'b0, S_FALL)};
    tbl[17] = '{4'b0100, 1'b1, mk( 0,  0, 1'b0, S_IDLE)};
    tbl[18] = '{4'b0100, 1'b1, mk( 0,  0, 1'b0, S_IDLE)};
    tbl[19] = '{4'b0000, 1'b1, mk( 0,  0, 1'b0, S_IDLE)};
    tbl[20] = '{4'b0001, 1'b0, mk( 1,  5, 1'b0, S_FALL)};
    tbl[21] = '{4'b0001, 1'b1, mk( 1,  0, 1'b0, S_WALK)};
    tbl[22] = '{4'b0100, 1'b0, mk( 0, -5, 1'b0, S_RISE)};

    repeat (2) @(posedge clk);
    apply_reset("reset0");

    for (int i = 0; i < 23; i++) begin
      do_tick(tbl[i].sw, tbl[i].og, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Reset while rising; jump must be re-armed afterwards.
    apply_reset("reset_mid_rise");
    do_tick(4'b0100, 1'b1, mk(0, -5, 1'b0, S_RISE), "rearm_after_reset");

    // Grounded kick beats jump; fixed duration, then cooldown window.
    apply_reset("reset1");
    do_tick(4'b0110, 1'b1, mk(0, 0, 1'b1, S_KICK), "kick_entry");
    for (int i = 0; i < 5; i++) begin
      do_tick(4'b0110, 1'b1, mk(0, 0, 1'b1, S_KICK), $sformatf("kick_hold%0d", i));
    end
    do_tick(4'b0111, 1'b1, mk(0, 0, 1'b0, S_IDLE), "kick_exit");
    for (int i = 1; i <= 14; i++) begin
      do_tick(4'b0010, 1'b1, mk(0, 0, 1'b0, S_IDLE), $sformatf("cooldown%0d", i));
    end
    do_tick(4'b0010, 1'b1, mk(0, 0, 1'b1, S_KICK), "kick_after_cd");

    // No frame ticks: everything, including the kick counter, must hold.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      sw        = 4'($urandom);
      on_ground = 1'($urandom);
      @(posedge clk);
      #1;
      if ((i % 10) == 9) begin
        check_out($sformatf("notick%0d", i), mk(0, 0, 1'b1, S_KICK));
      end
    end
    for (int i = 0; i < 5; i++) begin
      do_tick(4'b0000, 1'b1, mk(0, 0, 1'b1, S_KICK), $sformatf("kick_resume%0d", i));
    end
    do_tick(4'b0000, 1'b1, mk(0, 0, 1'b0, S_IDLE), "kick_resume_exit");
    do_tick(4'b0010, 1'b1, mk(0, 0, 1'b0, S_IDLE), "cd_reload");

    check_int("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
